// File: rtl/reg_bank_p_pkg.sv
// Shared address map and register bit positions for the reg_bank_p register bank.
package reg_bank_p_pkg;

    localparam int ADDR_STATUS = 0;
    localparam int ADDR_CTRL   = 1;
    localparam int ADDR_DATA0  = 2;

    localparam int ST_W        = 4;
    localparam int ST_WR_SEEN  = 0;
    localparam int ST_RD_SEEN  = 1;
    localparam int ST_DEC_ERR  = 2;
    localparam int ST_LOCK_ERR = 3;

    localparam int CTRL_LOCK   = 7;

endpackage

// File: rtl/reg_bank_p_decode.sv
// Full-width address decode into one-hot register selects plus an unmapped flag.
module reg_bank_p_decode
    import reg_bank_p_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int NUM_DATA = 4
)(
    input  logic [ADDR_W-1:0]   addr,
    output logic                sel_status,
    output logic                sel_ctrl,
    output logic [NUM_DATA-1:0] sel_data,
    output logic                unmapped
);

    // Every compare spans all ADDR_W bits so high addresses never alias low registers.
    assign sel_status = (addr == ADDR_W'(ADDR_STATUS));
    assign sel_ctrl   = (addr == ADDR_W'(ADDR_CTRL));

    for (genvar i = 0; i < NUM_DATA; i++) begin : g_data
        assign sel_data[i] = (addr == ADDR_W'(ADDR_DATA0 + i));
    end

    assign unmapped = ~(sel_status | sel_ctrl | (|sel_data));

endmodule

// File: rtl/reg_bank_p.sv
// Register bank: sticky W1C STATUS, CTRL with irq mask and DATA lock, NUM_DATA data registers.
module reg_bank_p
    import reg_bank_p_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 32,
    parameter int NUM_DATA = 4
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              direction,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    output logic              err,
    output logic              irq
);

    logic                             sel_status, sel_ctrl, unmapped;
    logic [NUM_DATA-1:0]              sel_data;
    logic [ST_W-1:0]                  status_q, status_set, status_clr, status_d;
    logic [DATA_W-1:0]                ctrl_q;
    logic [NUM_DATA-1:0][DATA_W-1:0]  data_q;
    logic [DATA_W-1:0]                rd_mux;
    logic                             wr, rd, locked, dec_err_ev, lock_err_ev;

    reg_bank_p_decode #(
        .ADDR_W   (ADDR_W),
        .NUM_DATA (NUM_DATA)
    ) u_decode (
        .addr       (addr),
        .sel_status (sel_status),
        .sel_ctrl   (sel_ctrl),
        .sel_data   (sel_data),
        .unmapped   (unmapped)
    );

    assign wr          = enable & direction;
    assign rd          = enable & ~direction;
    assign locked      = ctrl_q[CTRL_LOCK];
    assign dec_err_ev  = enable & unmapped;
    assign lock_err_ev = wr & locked & (|sel_data);

    // Set terms are OR'd after the clear so a same-cycle event wins over W1C.
    always_comb begin
        status_set              = '0;
        status_set[ST_WR_SEEN]  = wr;
        status_set[ST_RD_SEEN]  = rd;
        status_set[ST_DEC_ERR]  = dec_err_ev;
        status_set[ST_LOCK_ERR] = lock_err_ev;
        status_clr              = (wr & sel_status) ? wdata[ST_W-1:0] : '0;
        status_d                = (status_q & ~status_clr) | status_set;
    end

    // Unmapped reads fall through to zero; STATUS reads see the pre-update value.
    always_comb begin
        rd_mux = '0;
        if (sel_status)
            rd_mux = DATA_W'(status_q);
        else if (sel_ctrl)
            rd_mux = ctrl_q;
        for (int i = 0; i < NUM_DATA; i++)
            if (sel_data[i])
                rd_mux = data_q[i];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            status_q <= '0;
            ctrl_q   <= '0;
            data_q   <= '0;
            rdata    <= '0;
            rvalid   <= 1'b0;
            err      <= 1'b0;
        end else begin
            status_q <= status_d;
            rvalid   <= rd;
            err      <= dec_err_ev | lock_err_ev;
            if (rd)
                rdata <= rd_mux;
            if (wr & sel_ctrl)
                ctrl_q <= wdata;
            for (int i = 0; i < NUM_DATA; i++)
                if (wr & sel_data[i] & ~locked)
                    data_q[i] <= wdata;
        end
    end

    assign irq = |(status_q & ctrl_q[ST_W-1:0]);

endmodule

// File: tb/tb_reg_bank_p.sv
// Scoreboard bench: two reg_bank_p instances (8b/4 regs and 32b/16 regs) vs. a behavioural model.
module tb_reg_bank_p;

    typedef struct packed {
        logic [31:0]      due;
        logic [1:0]       rv;
        logic [1:0]       er;
        logic [1:0]       iq;
        logic [1:0][31:0] rd;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, enable, direction;
    logic [31:0] addr, wdata;
    logic [7:0]  rdata_a;
    logic [31:0] rdata_b;
    logic        rvalid_a, err_a, irq_a, rvalid_b, err_b, irq_b;

    int unsigned n_tests = 0, n_fail = 0;
    logic [31:0] cyc = 0;
    exp_t        sb[$];
    exp_t        mon_e;

    // Reference state, one slot per instance: 0 = 8-bit/4 regs, 1 = 32-bit/16 regs.
    bit [3:0]  m_st[2];
    bit [31:0] m_ctrl[2];
    bit [31:0] m_data[2][16];
    bit [31:0] m_rd[2];

    reg_bank_p u_dut_a (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .direction (direction),
        .addr      (addr),
        .wdata     (wdata[7:0]),
        .rdata     (rdata_a),
        .rvalid    (rvalid_a),
        .err       (err_a),
        .irq       (irq_a)
    );

    reg_bank_p #(.DATA_W(32), .ADDR_W(32), .NUM_DATA(16)) u_dut_b (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .direction (direction),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata_b),
        .rvalid    (rvalid_b),
        .err       (err_b),
        .irq       (irq_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic model_step(input int i, input bit r, input bit en, input bit dir,
                              input bit [31:0] a, input bit [31:0] wd_in,
                              output logic rv, output logic er, output logic iq,
                              output logic [31:0] rdv);
        int        nd  = (i == 0) ? 4 : 16;
        bit [31:0] wd  = wd_in & ((i == 0) ? 32'hFF : 32'hFFFF_FFFF);
        bit [3:0]  set = '0;
        bit [3:0]  clr = '0;
        rv = 1'b0;
        er = 1'b0;
        if (r) begin
            m_st[i]   = '0;
            m_ctrl[i] = '0;
            m_rd[i]   = '0;
            for (int j = 0; j < 16; j++) m_data[i][j] = '0;
        end else if (en) begin
            if (dir) set[0] = 1'b1; else set[1] = 1'b1;
            if (a >= 32'(2 + nd)) begin
                set[2] = 1'b1;
                er     = 1'b1;
                if (!dir) begin rv = 1'b1; m_rd[i] = '0; end
            end else if (dir) begin
                if (a == 0)                clr = wd[3:0];
                else if (a == 1)           m_ctrl[i] = wd;
                else if (m_ctrl[i][7])     begin set[3] = 1'b1; er = 1'b1; end
                else                       m_data[i][a-2] = wd;
            end else begin
                rv = 1'b1;
                if (a == 0)      m_rd[i] = {28'b0, m_st[i]};
                else if (a == 1) m_rd[i] = m_ctrl[i];
                else             m_rd[i] = m_data[i][a-2];
            end
            m_st[i] = (m_st[i] & ~clr) | set;
        end
        iq  = |(m_st[i] & m_ctrl[i][3:0]);
        rdv = m_rd[i];
    endtask

    task automatic drive(input bit r, input bit en, input bit dir,
                         input bit [31:0] a, input bit [31:0] wd);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; enable = en; direction = dir; addr = a; wdata = wd;
        e.due = cyc + 1;
        for (int i = 0; i < 2; i++)
            model_step(i, r, en, dir, a, wd, e.rv[i], e.er[i], e.iq[i], e.rd[i]);
        sb.push_back(e);
    endtask

    task automatic wr(input bit [31:0] a, input bit [31:0] d); drive(0, 1, 1, a, d); endtask
    task automatic rd(input bit [31:0] a); drive(0, 1, 0, a, $urandom); endtask
    task automatic idle(); drive(0, 0, 1'($urandom), $urandom, $urandom); endtask

    task automatic check(input int i, input logic rv, input logic er, input logic iq,
                         input logic [31:0] rdv, input exp_t e);
        n_tests++;
        if (rv !== e.rv[i] || er !== e.er[i] || iq !== e.iq[i] || rdv !== e.rd[i]) begin
            n_fail++;
            $display("FAIL dut%0d cyc%0d: got rvalid=%b err=%b irq=%b rdata=%h, want rvalid=%b err=%b irq=%b rdata=%h",
                     i, cyc, rv, er, iq, rdv, e.rv[i], e.er[i], e.iq[i], e.rd[i]);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0 && sb[0].due < cyc) begin
            mon_e = sb.pop_front();
            n_tests++;
            n_fail++;
            $display("FAIL stale_expect: due cyc%0d, now cyc%0d", mon_e.due, cyc);
        end
        if (sb.size() > 0 && sb[0].due == cyc) begin
            mon_e = sb.pop_front();
            check(0, rvalid_a, err_a, irq_a, {24'b0, rdata_a}, mon_e);
            check(1, rvalid_b, err_b, irq_b, rdata_b, mon_e);
        end
    end

    initial begin
        rst = 1'b1; enable = 1'b0; direction = 1'b0; addr = '0; wdata = '0;
        drive(1, 1, 0, 2, 0);
        drive(1, 0, 0, 0, 0);
        rd(0); rd(1); rd(2);

        // Basic write/read, then STATUS shows WR_SEEN|RD_SEEN.
        drive(1, 0, 0, 0, 0);
        wr(2, 32'hA5); rd(2); rd(0);

        // Unmapped access, including high bits that would alias if truncated.
        wr(0, 32'hF); wr(32'h40, 32'h77); rd(32'h40); rd(0);
        wr(32'h8000_0002, 32'h11); rd(32'h1_0002); rd(2);

        // Lock blocks DATA writes but CTRL stays writable.
        wr(1, 32'h80); wr(3, 32'h3C); rd(3); rd(0);
        wr(1, 32'h00); wr(3, 32'h3C); rd(3);

        // DEC_ERR interrupt, cleared by W1C.
        wr(0, 32'hF); wr(1, 32'h04); rd(32'h40); idle(); wr(0, 32'h04); idle(); idle();

        // W1C of WR_SEEN loses to the write's own set.
        wr(0, 32'h01); rd(0); wr(1, 32'h0F); idle();

        // Wide instance upper register, then reset mid-read.
        wr(17, 32'hDEAD_BEEF); rd(17); rd(17);
        drive(1, 1, 0, 17, 0); idle();
        for (int a = 0; a < 19; a++) rd(a);

        for (int n = 0; n < 700; n++) begin
            int unsigned k  = $urandom_range(0, 99);
            int unsigned ak = $urandom_range(0, 9);
            bit [31:0]   a, wd;
            if (ak < 8)       a = $urandom_range(0, 19);
            else if (ak == 8) a = $urandom;
            else              a = 32'h0001_0000 | $urandom_range(0, 3);
            wd = $urandom;
            if (a == 1 && $urandom_range(0, 3) != 0) wd[7] = 1'b0;
            drive(k < 2, $urandom_range(0, 4) != 0, 1'($urandom), a, wd);
        end

        idle(); idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expectations never checked, want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_bank_p.md
REG_BANK_P -- requirements
Module: reg_bank_p

Interface
REQ-001 SHALL have parameter DATA_W, default 8, register/bus data width (legal 8..32).
REQ-002 SHALL have parameter ADDR_W, default 32, address bus width.
REQ-003 SHALL have parameter NUM_DATA, default 4, number of data registers (legal 1..16).
REQ-004 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst, input, 1, reset, synchronous, active-high.
REQ-006 SHALL have port enable, input, 1, access request, one access per asserted cycle.
REQ-007 SHALL have port direction, input, 1, 1 = write, 0 = read.
REQ-008 SHALL have port addr, input, ADDR_W, word address.
REQ-009 SHALL have port wdata, input, DATA_W, write data.
REQ-010 SHALL have port rdata, output, DATA_W, registered read data.
REQ-011 SHALL have port rvalid, output, 1, one-cycle pulse qualifying rdata.
REQ-012 SHALL have port err, output, 1, one-cycle pulse on decode or lock error.
REQ-013 SHALL have port irq, output, 1, level interrupt.

Function
REQ-014 SHALL use this address map: 0 STATUS, 1 CTRL, 2..NUM_DATA+1 DATA[0..NUM_DATA-1]; all other addresses are unmapped.
REQ-015 SHALL define STATUS bits: [0] WR_SEEN, [1] RD_SEEN, [2] DEC_ERR, [3] LOCK_ERR, all sticky; upper bits read 0.
REQ-016 SHALL define CTRL bits: [3:0] IRQ_EN mask for STATUS[3:0]; [7] LOCK; other bits read/write storage; bits at index >= DATA_W absent.
REQ-017 SHALL perform a write (enable=1, direction=1) on the clock edge of the request cycle; no wait states.
REQ-018 SHALL, on a read (enable=1, direction=0), drive rdata and pulse rvalid exactly one cycle after the request (latency 1).
REQ-019 SHALL hold rdata at its last value when rvalid=0.
REQ-020 SHALL treat STATUS writes as write-1-to-clear per bit; zero bits unaffected.
REQ-021 SHALL, when CTRL[7]=1, ignore writes to DATA registers, set LOCK_ERR, and pulse err one cycle later; CTRL and STATUS stay writable.
REQ-022 SHALL, on any access to an unmapped address, set DEC_ERR, pulse err one cycle later, discard write data, and return 0 with rvalid on reads.
REQ-023 SHALL set WR_SEEN on every write and RD_SEEN on every read, mapped or not.
REQ-024 SHALL give a set event priority over a W1C clear of the same bit in the same cycle.
REQ-025 SHALL return the pre-update value when STATUS is read in the cycle a set event occurs.
REQ-026 SHALL drive irq = OR over (STATUS[3:0] AND CTRL[3:0]), combinational from registered state.
REQ-027 SHALL compare the full ADDR_W address; no aliasing from truncation.
REQ-028 SHALL ignore direction, addr and wdata when enable=0.

Reset
REQ-029 SHALL, while rst=1 at a clock edge, clear STATUS, CTRL, all DATA, rdata, rvalid and err to 0; irq is therefore 0.
REQ-030 SHALL abandon an access requested in the cycle rst is asserted; no rvalid or err follows.

Structure
REQ-031 SHALL place address constants, STATUS/CTRL bit indices and the LOCK bit index in package reg_bank_p_pkg.
REQ-032 SHALL implement address decode in one sub-module, reg_bank_p_decode, producing one-hot selects plus an unmapped flag.

Verification
REQ-033 SHALL cover: write 8'hA5 to addr 2, read addr 2 -> rvalid 1 cycle after read, rdata=8'hA5, STATUS=8'h03.
REQ-034 SHALL cover: write addr 8'h40 -> err pulse next cycle, STATUS[2]=1, read 8'h40 returns 0 with rvalid.
REQ-035 SHALL cover: CTRL=8'h80, write 8'h3C to addr 3 -> DATA[1] unchanged, err pulse, STATUS[3]=1.
REQ-036 SHALL cover: CTRL=8'h04, provoke DEC_ERR -> irq=1; write STATUS 8'h04 -> irq=0 next cycle.
REQ-037 SHALL cover: W1C of STATUS bit 0 together with a write -> WR_SEEN remains 1.
REQ-038 SHALL cover: DATA_W=32, NUM_DATA=16: write/read 32'hDEADBEEF at addr 17; rst during read -> no rvalid, all registers 0.
